imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate generator and sign/zero extender for the RV32/RV64 datapath. It replaces fixed-width single-format extenders with one block. The block decodes the immediate field of a 32-bit instruction for a selected format, extends it to XLEN bits, and delivers it through a 2-stage valid/ready elastic pipeline. It sits between the decode stage and the PC-target / ALU-operand muxes.

---
 rtl/imm_pkg.sv | 42 ++++
 rtl/imm_pipe_slice.sv | 39 +++
 rtl/imm_extend_pipe.sv | 153 +++++++++++++++
 tb/tb_imm_extend_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator.
//   - FMT_* : encodings of the fmt select (6 and 7 are illegal)
//   - W_*   : raw immediate widths before extension
//   - sext  : extends a right-aligned raw field of width w to xlen bits
package imm_pkg;

  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_S     = 3'd1;
  localparam logic [2:0] FMT_B     = 3'd2;
  localparam logic [2:0] FMT_U     = 3'd3;
  localparam logic [2:0] FMT_J     = 3'd4;
  localparam logic [2:0] FMT_SHAMT = 3'd5;

  localparam int unsigned W_I = 12;
  localparam int unsigned W_S = 12;
  localparam int unsigned W_B = 13;
  localparam int unsigned W_U = 32;
  localparam int unsigned W_J = 21;

  // Bits [w-1:0] pass through, bits [xlen-1:w] take raw[w-1] (or 0 when zext),
  // bits above xlen are cleared. w = 0 yields all zeros.
  function automatic logic [63:0] sext(input logic [63:0]  raw,
                                       input int unsigned  w,
                                       input logic         zext,
                                       input int unsigned  xlen);
    logic        fill;
    logic [63:0] res;
    fill = 1'b0;
    res  = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i + 1 == w) fill = raw[i];
    end
    if (zext) fill = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < w)         res[i] = raw[i];
      else if (i < xlen) res[i] = fill;
      else               res[i] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/imm_pipe_slice.sv
// Generic valid/ready register slice. Loads when empty or when its content
// leaves in the same cycle, so a chain of slices sustains one transfer per cycle.
//   clk_i, rst_ni            : clock, async active-low reset
//   in_valid_i / in_ready_o  : upstream handshake
//   in_data_i                : upstream payload (Width bits)
//   out_valid_o / out_ready_i: downstream handshake
//   out_data_o               : registered payload, held while stalled
module imm_pipe_slice #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      // Payload only changes on a real transfer, keeping it stable on bubbles.
      if (in_valid_i) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator / extender for RV32 and RV64.
// Stage 1 registers instr/fmt/zext; extraction and extension are combinational
// between stage 1 and stage 2; stage 2 registers imm and out_fmt.
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in_ready  : input handshake (in_ready depends on out_ready and state)
//   instr, fmt, zext    : instruction word, format select, force zero-extend
//   out_valid, out_ready: output handshake
//   imm, out_fmt        : extended immediate (XLEN bits), format carried along
//   illegal             : only with IMM_ILLEGAL_FMT_EN defined; set for fmt 6/7
// Parameters: XLEN (32 or 64), ZEXT_SHAMT (1 = SHAMT always zero-extends).
module imm_extend_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter bit          ZEXT_SHAMT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      fmt,
  input  logic            zext,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      out_fmt
`ifdef IMM_ILLEGAL_FMT_EN
  ,
  output logic            illegal
`endif
);

  import imm_pkg::*;

  localparam int unsigned S1W     = 36;
  localparam int unsigned W_SHAMT = (XLEN == 64) ? 6 : 5;
`ifdef IMM_ILLEGAL_FMT_EN
  localparam int unsigned S2W = XLEN + 4;
`else
  localparam int unsigned S2W = XLEN + 3;
`endif

  logic            s1_valid;
  logic            s2_ready;
  logic [S1W-1:0]  s1_data;
  logic [31:0]     s1_instr;
  logic [2:0]      s1_fmt;
  logic            s1_zext;
  logic [S2W-1:0]  s2_in;
  logic [S2W-1:0]  s2_data;
  logic [63:0]     raw;
  logic [63:0]     ext_full;
  int unsigned     raw_w;
  logic            fill_zero;
  logic [XLEN-1:0] imm_d;
  logic            unused_opcode;

  imm_pipe_slice #(
    .Width (S1W)
  ) u_stage1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({zext, fmt, instr}),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_data)
  );

  assign s1_instr = s1_data[31:0];
  assign s1_fmt   = s1_data[34:32];
  assign s1_zext  = s1_data[35];

  // Opcode bits never contribute to any immediate.
  assign unused_opcode = ^s1_instr[6:0];

  always_comb begin
    raw       = '0;
    raw_w     = 0;
    fill_zero = s1_zext;
    case (s1_fmt)
      FMT_I: begin
        raw[11:0] = s1_instr[31:20];
        raw_w     = W_I;
      end
      FMT_S: begin
        raw[11:0] = {s1_instr[31:25], s1_instr[11:7]};
        raw_w     = W_S;
      end
      FMT_B: begin
        raw[12:0] = {s1_instr[31], s1_instr[7], s1_instr[30:25], s1_instr[11:8], 1'b0};
        raw_w     = W_B;
      end
      FMT_U: begin
        // Width 32 means RV64 sign-extends from bit 31 through the common path.
        raw[31:0] = {s1_instr[31:12], 12'b0};
        raw_w     = W_U;
      end
      FMT_J: begin
        raw[20:0] = {s1_instr[31], s1_instr[19:12], s1_instr[20], s1_instr[30:21], 1'b0};
        raw_w     = W_J;
      end
      FMT_SHAMT: begin
        // RV32 shift amounts are 5 bits; instr[25] is ignored there.
        if (XLEN == 64) raw[5:0] = s1_instr[25:20];
        else            raw[4:0] = s1_instr[24:20];
        raw_w = W_SHAMT;
        if (ZEXT_SHAMT) fill_zero = 1'b1;
      end
      default: begin
        // Illegal formats: raw_w = 0 produces an all-zero immediate.
        raw   = '0;
        raw_w = 0;
      end
    endcase
  end

  assign ext_full = sext(raw, raw_w, fill_zero, XLEN);
  assign imm_d    = ext_full[XLEN-1:0];

  if (XLEN < 64) begin : g_ext_hi_unused
    logic unused_ext_hi;
    assign unused_ext_hi = ^ext_full[63:XLEN];
  end

`ifdef IMM_ILLEGAL_FMT_EN
  logic illegal_fmt;
  assign illegal_fmt = (s1_fmt == 3'd6) | (s1_fmt == 3'd7);
  assign s2_in       = {illegal_fmt, s1_fmt, imm_d};
`else
  assign s2_in       = {s1_fmt, imm_d};
`endif

  imm_pipe_slice #(
    .Width (S2W)
  ) u_stage2 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   (s2_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (s2_data)
  );

  assign imm     = s2_data[XLEN-1:0];
  assign out_fmt = s2_data[XLEN+2:XLEN];
`ifdef IMM_ILLEGAL_FMT_EN
  assign illegal = s2_data[XLEN+3];
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: an RV32 and an RV64 instance share all
// inputs; expected values are hand-computed constants.
module tb_imm_extend_pipe;

  import imm_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  fmt;
  logic        zext;
  logic        out_ready;

  logic        in_ready32, in_ready64;
  logic        out_valid32, out_valid64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
`ifdef IMM_ILLEGAL_FMT_EN
  logic        ill32, ill64;
`endif

  int nvec = 0;
  int nmis = 0;

  imm_extend_pipe #(
    .XLEN (32)
  ) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .instr     (instr),
    .fmt       (fmt),
    .zext      (zext),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .imm       (imm32),
    .out_fmt   (fmt32)
`ifdef IMM_ILLEGAL_FMT_EN
    ,
    .illegal   (ill32)
`endif
  );

  imm_extend_pipe #(
    .XLEN (64)
  ) dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready64),
    .instr     (instr),
    .fmt       (fmt),
    .zext      (zext),
    .out_valid (out_valid64),
    .out_ready (out_ready),
    .imm       (imm64),
    .out_fmt   (fmt64)
`ifdef IMM_ILLEGAL_FMT_EN
    ,
    .illegal   (ill64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] f, input logic z);
    in_valid = v;
    instr    = i;
    fmt      = f;
    zext     = z;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, FMT_I, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid32, 0);
    chk("rst_imm32", imm32, 0);
    chk("rst_imm64", imm64, 0);
    chk("rst_out_fmt", fmt32, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready32, 1);

    // I-format sign extension, latency 2
    drive(1'b1, 32'hFFF00093, FMT_I, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("lat_not_yet", out_valid32, 0);
    tick();
    chk("lat_valid", out_valid32, 1);
    chk("i_sext32", imm32, 64'hFFFFFFFF);
    chk("i_sext64", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("i_fmt", fmt32, 0);
    tick();
    chk("bubble_drop", out_valid32, 0);

    // I-format zero extension
    drive(1'b1, 32'hFFF00093, FMT_I, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("i_zext32", imm32, 64'h00000FFF);
    chk("i_zext64", imm64, 64'h0000000000000FFF);
    tick();

    // Back-to-back J, B, U, S
    drive(1'b1, 32'hFFDFF06F, FMT_J, 1'b0);
    chk("b2b_rdy0", in_ready32, 1);
    tick();
    drive(1'b1, 32'hFE000CE3, FMT_B, 1'b0);
    chk("b2b_rdy1", in_ready32, 1);
    tick();
    chk("b2b_j", imm32, 64'hFFFFFFFC);
    chk("b2b_j_fmt", fmt32, 4);
    chk("b2b_j64", imm64, 64'hFFFFFFFFFFFFFFFC);
    drive(1'b1, 32'h12345037, FMT_U, 1'b0);
    chk("b2b_rdy2", in_ready32, 1);
    tick();
    chk("b2b_b", imm32, 64'hFFFFFFF8);
    chk("b2b_b_fmt", fmt32, 2);
    drive(1'b1, 32'h00112623, FMT_S, 1'b0);
    chk("b2b_rdy3", in_ready32, 1);
    tick();
    chk("b2b_u", imm32, 64'h12345000);
    chk("b2b_u_fmt", fmt32, 3);
    in_valid = 1'b0;
    tick();
    chk("b2b_s", imm32, 64'h0000000C);
    chk("b2b_s_valid", out_valid32, 1);
    tick();
    chk("b2b_empty", out_valid32, 0);

    // Backpressure: 4 inputs, output stalled for 5 cycles
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, FMT_I, 1'b0);
    #1;
    chk("bp_rdy0", in_ready32, 1);
    tick();
    drive(1'b1, 32'h80000093, FMT_I, 1'b0);
    chk("bp_rdy1", in_ready32, 1);
    tick();
    drive(1'b1, 32'h7FF00093, FMT_I, 1'b0);
    chk("bp_full", in_ready32, 0);
    chk("bp_full64", in_ready64, 0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", out_valid32, 1);
      chk("bp_hold_imm", imm32, 64'h00000001);
      chk("bp_hold_rdy", in_ready32, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", in_ready32, 1);
    chk("bp_out0", imm32, 64'h00000001);
    tick();
    chk("bp_out1", imm32, 64'hFFFFF800);
    chk("bp_out1_v", out_valid32, 1);
    drive(1'b1, 32'h00500093, FMT_I, 1'b0);
    tick();
    chk("bp_out2", imm32, 64'h000007FF);
    in_valid = 1'b0;
    tick();
    chk("bp_out3", imm32, 64'h00000005);
    chk("bp_out3_v", out_valid32, 1);
    tick();
    chk("bp_drained", out_valid32, 0);

    // Illegal format followed by a legal one
    drive(1'b1, 32'hFFFFFFFF, 3'd7, 1'b0);
    tick();
    drive(1'b1, 32'hFFF00093, FMT_I, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("ill_valid", out_valid32, 1);
    chk("ill_imm32", imm32, 0);
    chk("ill_imm64", imm64, 0);
    chk("ill_fmt", fmt32, 7);
`ifdef IMM_ILLEGAL_FMT_EN
    chk("ill_flag", ill32, 1);
    chk("ill_flag64", ill64, 1);
`endif
    tick();
    chk("ill_next_imm", imm32, 64'hFFFFFFFF);
`ifdef IMM_ILLEGAL_FMT_EN
    chk("ill_flag_clr", ill32, 0);
`endif
    tick();

    // RV64 specifics: J, U sign from bit 31, SHAMT width
    drive(1'b1, 32'hFFDFF06F, FMT_J, 1'b0);
    tick();
    drive(1'b1, 32'h80000037, FMT_U, 1'b0);
    tick();
    chk("x64_j", imm64, 64'hFFFFFFFFFFFFFFFC);
    drive(1'b1, 32'h03F01093, FMT_SHAMT, 1'b0);
    tick();
    chk("x64_u", imm64, 64'hFFFFFFFF80000000);
    chk("x32_u", imm32, 64'h80000000);
    in_valid = 1'b0;
    tick();
    chk("x64_shamt", imm64, 64'h000000000000003F);
    chk("x32_shamt", imm32, 64'h0000001F);
    chk("x64_shamt_fmt", fmt64, 5);
    tick();

    // Asynchronous reset with two entries in flight
    out_ready = 1'b0;
    drive(1'b1, 32'h7FF00093, FMT_I, 1'b0);
    tick();
    drive(1'b1, 32'h00500093, FMT_I, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", out_valid32, 1);
    chk("ar_pre_imm", imm32, 64'h000007FF);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid32, 0);
    chk("ar_imm32", imm32, 0);
    chk("ar_imm64", imm64, 0);
    chk("ar_fmt", fmt32, 0);
    chk("ar_rdy", in_ready32, 1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("ar_no_stale0", out_valid32, 0);
    tick();
    chk("ar_no_stale1", out_valid32, 0);
    drive(1'b1, 32'h00112623, FMT_S, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("ar_after_imm", imm32, 64'h0000000C);
    chk("ar_after_fmt", fmt32, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
